// File: rtl/score_pkg.sv
`default_nettype none
// ============================================================================
// Module  : score_pkg
// Purpose : Shared constants, types and helpers for the score display path.
//           Holds the active-low seven-segment digit patterns, the score
//           ceiling, the BCD geometry and the converter state encoding.
// Ports   : (package, none)
// Revision: 1.0  initial release
// ============================================================================
package score_pkg;

  localparam int SCORE_MAX  = 9999;
  localparam int BCD_DIGITS = 4;
  localparam int BCD_W      = 4 * BCD_DIGITS;

  // Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
  localparam logic [6:0] SEG_OFF = 7'b1111111;
  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000   // 9
  };

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } conv_state_t;

  // Decode one BCD nibble; codes above 9 light nothing.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    if (nib <= 4'd9) begin
      return SEG_DIGIT[nib];
    end
    return SEG_OFF;
  endfunction

  // Double-dabble correction: every nibble of 5 or more gets +3 so that the
  // following left shift carries correctly into the next decimal digit.
  function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] res;
    res = bcd;
    for (int k = 0; k < BCD_DIGITS; k++) begin
      if (res[4*k +: 4] >= 4'd5) begin
        res[4*k +: 4] = res[4*k +: 4] + 4'd3;
      end
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module  : bin2bcd_seq
// Purpose : Iterative double-dabble binary-to-BCD converter (IDLE/SHIFT/DONE).
//           One bit is shifted per cycle; the result is latched on DONE.
// Ports   : i_clk    - clock
//           i_rst    - synchronous active-low reset
//           i_start  - request a conversion of i_bin (honoured in IDLE only)
//           i_bin    - binary value to convert
//           o_last   - value whose BCD is currently on o_bcd
//           o_busy   - high from the start edge until the result is latched
//           o_bcd    - latched BCD result, [3:0] = ones digit
// Revision: 1.0  initial release
// ============================================================================
module bin2bcd_seq
  import score_pkg::*;
#(
  parameter int SCORE_W = 14
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [SCORE_W-1:0] i_bin,
  output logic [SCORE_W-1:0] o_last,
  output logic               o_busy,
  output logic [BCD_W-1:0]   o_bcd
);

  localparam int               CNT_W     = (SCORE_W > 1) ? $clog2(SCORE_W) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(SCORE_W - 1);

  conv_state_t        state;
  conv_state_t        state_next;
  logic [SCORE_W-1:0] bin_sr;
  logic [SCORE_W-1:0] sample;
  logic [BCD_W-1:0]   bcd_acc;
  logic [BCD_W-1:0]   bcd_adj;
  logic [CNT_W-1:0]   count;

  assign bcd_adj = bcd_adjust(bcd_acc);

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (i_start) state_next = ST_SHIFT;
      ST_SHIFT: if (count == LAST_STEP) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      bin_sr  <= '0;
      sample  <= '0;
      bcd_acc <= '0;
      count   <= '0;
      o_last  <= '0;
      o_busy  <= 1'b0;
      o_bcd   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            bin_sr  <= i_bin;
            sample  <= i_bin;
            bcd_acc <= '0;
            count   <= '0;
            o_busy  <= 1'b1;
          end
        end
        ST_SHIFT: begin
          // {bcd,bin} <<= 1 after the nibble correction.
          bcd_acc <= {bcd_adj[BCD_W-2:0], bin_sr[SCORE_W-1]};
          bin_sr  <= {bin_sr[SCORE_W-2:0], 1'b0};
          count   <= count + CNT_W'(1);
        end
        ST_DONE: begin
          o_bcd  <= bcd_acc;
          o_last <= sample;
          o_busy <= 1'b0;
        end
        default: begin
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/score_display.sv
`default_nettype none
// ============================================================================
// Module  : score_display
// Purpose : Drives a 4-digit multiplexed seven-segment display from a binary
//           score. Saturates at 9999, converts to BCD, scans the anodes and
//           optionally blanks leading zeros.
// Ports   : i_clk    - clock
//           i_rst    - synchronous active-low reset
//           i_score  - binary score
//           i_blank  - 1 forces all anodes off
//           o_bcd    - BCD of the last converted score, [3:0] = ones
//           o_busy   - conversion in progress
//           o_an     - active-low anode enables, bit 0 = ones digit
//           o_seg    - active-low segments {g,f,e,d,c,b,a}
// Revision: 1.0  initial release
// ============================================================================
module score_display
  import score_pkg::*;
#(
  parameter int REFRESH_DIV = 100_000,
  parameter int LZB         = 1,
  parameter int SCORE_W     = 14
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [SCORE_W-1:0] i_score,
  input  logic               i_blank,
  output logic [15:0]        o_bcd,
  output logic               o_busy,
  output logic [3:0]         o_an,
  output logic [6:0]         o_seg
);

  localparam int              RC_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(REFRESH_DIV - 1);

  logic [SCORE_W-1:0] sat;
  logic [SCORE_W-1:0] last;
  logic               start;
  logic [RC_W-1:0]    refresh_cnt;
  logic [1:0]         digit_idx;
  logic [3:0]         nib;
  logic               lead_zero;
  logic [3:0]         an_next;

  assign sat   = (int'(i_score) > SCORE_MAX) ? SCORE_W'(SCORE_MAX) : i_score;
  // A new conversion is wanted whenever the displayed value is stale; the
  // converter ignores this while it is already busy.
  assign start = (sat != last);

  bin2bcd_seq #(
    .SCORE_W (SCORE_W)
  ) u_conv (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_start (start),
    .i_bin   (sat),
    .o_last  (last),
    .o_busy  (o_busy),
    .o_bcd   (o_bcd)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      refresh_cnt <= '0;
      digit_idx   <= 2'd0;
    end else if (refresh_cnt == RC_LAST) begin
      refresh_cnt <= '0;
      digit_idx   <= digit_idx + 2'd1;
    end else begin
      refresh_cnt <= refresh_cnt + RC_W'(1);
    end
  end

  // Current nibble, and whether it and every more significant digit is zero.
  always_comb begin
    nib       = 4'd0;
    lead_zero = 1'b0;
    case (digit_idx)
      2'd0: begin
        nib       = o_bcd[3:0];
        lead_zero = 1'b0;
      end
      2'd1: begin
        nib       = o_bcd[7:4];
        lead_zero = (o_bcd[15:4] == 12'd0);
      end
      2'd2: begin
        nib       = o_bcd[11:8];
        lead_zero = (o_bcd[15:8] == 8'd0);
      end
      2'd3: begin
        nib       = o_bcd[15:12];
        lead_zero = (o_bcd[15:12] == 4'd0);
      end
      default: begin
        nib       = 4'd0;
        lead_zero = 1'b0;
      end
    endcase
  end

  always_comb begin
    an_next = ~(4'b0001 << digit_idx);
    if (i_blank || ((LZB != 0) && lead_zero)) begin
      an_next = 4'b1111;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      o_an  <= 4'b1110;
      o_seg <= SEG_DIGIT[0];
    end else begin
      o_an  <= an_next;
      o_seg <= seg_decode(nib);
    end
  end

endmodule
`default_nettype wire
